// File: rtl/sent_pkg.sv
// Shared encodings, limits and the frame legality check
// for the SENT parameter-frame parser.
package sent_pkg;

   typedef enum logic [1:0] {
      PAUSE_NONE  = 2'd0,
      PAUSE_FIXED = 2'd1,
      PAUSE_VAR   = 2'd2,
      PAUSE_RSVD  = 2'd3
   } pause_mode_e;

   typedef enum logic {
      CRC_LEGACY      = 1'b0,
      CRC_RECOMMENDED = 1'b1
   } crc_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      W1,
      W2,
      DROP
   } parse_state_e;

   localparam logic [7:0]  CTICK_MIN   = 8'd3;
   localparam logic [7:0]  CTICK_MAX   = 8'd90;
   localparam logic [7:0]  LTICK_MIN   = 8'd4;
   localparam logic [15:0] PAUSE_MIN   = 16'd12;
   localparam logic [15:0] PAUSE_MAX   = 16'd768;
   localparam int          FRAME_WORDS = 3;

   function automatic logic frame_ok(
      input logic [7:0]  ch,
      input logic [7:0]  num,
      input logic [7:0]  ctick,
      input logic [7:0]  ltick,
      input logic [1:0]  pmode,
      input logic [15:0] plen
   );
      logic pause_ok;
      pause_ok = (pmode == PAUSE_NONE) ||
                 ((plen >= PAUSE_MIN) && (plen <= PAUSE_MAX));
      return (ch < num) &&
             (ctick >= CTICK_MIN) && (ctick <= CTICK_MAX) &&
             (ltick >= LTICK_MIN) &&
             (pmode != PAUSE_RSVD) && pause_ok;
   endfunction

endpackage

// File: rtl/sent_param_parser.sv
// Parses 3-word SENT parameter frames from a UDP word stream
// into per-channel configuration writes.
module sent_param_parser
   import sent_pkg::*;
#(
   parameter int          SENT_NUM      = 5,
   parameter logic [15:0] ID_SENT_PARAM = 16'd2,
   parameter int          CLK_FREQ      = 100000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         rx_axis_udp_tdata,
   input  logic                rx_axis_udp_tvalid,
   input  logic                rx_axis_udp_tlast,
   output logic [SENT_NUM-1:0] cfg_wr,
   output logic [13:0]         cfg_ctick_clk,
   output logic [7:0]          cfg_ltick_len,
   output logic [1:0]          cfg_pause_mode,
   output logic [9:0]          cfg_pause_len,
   output logic                cfg_crc_mode,
   output logic                frame_err,
   output logic [15:0]         err_cnt
);

   localparam int MHZ = CLK_FREQ / 1000000;

   parse_state_e state;
   logic [7:0]   ch_q;
   logic [7:0]   ctick_q;
   logic [7:0]   ltick_q;
   logic [1:0]   pmode_q;
   logic [7:0]   plen_hi_q;
   logic [15:0]  plen;
   logic         last;
   logic         id_hit;
   logic         ok;
   logic         rej;
   logic         acc;

   assign last   = rx_axis_udp_tlast;
   assign id_hit = rx_axis_udp_tdata[31:16] == ID_SENT_PARAM;
   assign plen   = {plen_hi_q, rx_axis_udp_tdata[31:24]};
   assign ok     = frame_ok(ch_q, 8'(SENT_NUM), ctick_q,
                            ltick_q, pmode_q, plen);

   always_comb begin
      rej = 1'b0;
      acc = 1'b0;
      if (rx_axis_udp_tvalid) begin
         unique case (state)
            IDLE:    rej = id_hit && last;
            W1:      rej = last;
            W2: begin
               rej = !last || !ok;
               acc = last && ok;
            end
            default: rej = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ch_q      <= '0;
         ctick_q   <= '0;
         ltick_q   <= '0;
         pmode_q   <= '0;
         plen_hi_q <= '0;
      end else if (rx_axis_udp_tvalid) begin
         unique case (state)
            IDLE: begin
               ch_q <= rx_axis_udp_tdata[15:8];
               if (id_hit && !last)
                  state <= W1;
               else if (!id_hit && !last)
                  state <= DROP;
            end
            W1: begin
               if (last) begin
                  state <= IDLE;
               end else begin
                  ctick_q   <= rx_axis_udp_tdata[31:24];
                  ltick_q   <= rx_axis_udp_tdata[23:16];
                  pmode_q   <= rx_axis_udp_tdata[9:8];
                  plen_hi_q <= rx_axis_udp_tdata[7:0];
                  state     <= W2;
               end
            end
            W2:      state <= last ? IDLE : DROP;
            DROP:    if (last) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // ctick scaling is a constant multiply; MHZ folds at elaboration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_wr         <= '0;
         cfg_ctick_clk  <= '0;
         cfg_ltick_len  <= '0;
         cfg_pause_mode <= '0;
         cfg_pause_len  <= '0;
         cfg_crc_mode   <= 1'b0;
         frame_err      <= 1'b0;
         err_cnt        <= '0;
      end else begin
         cfg_wr    <= '0;
         frame_err <= rej;
         if (rej && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
         if (acc) begin
            cfg_wr         <= SENT_NUM'(1) << ch_q;
            cfg_ctick_clk  <= 14'(ctick_q * MHZ);
            cfg_ltick_len  <= ltick_q;
            cfg_pause_mode <= pmode_q;
            cfg_pause_len  <= plen[9:0];
            cfg_crc_mode   <= rx_axis_udp_tdata[16];
         end
      end
   end

endmodule

// File: doc/sent_param_parser.md
SENT_PARAM_PARSER -- requirements
Module: sent_param_parser

Interface
REQ-001 SHALL have parameter SENT_NUM, default 5, number of SENT channels (1..255).
REQ-002 SHALL have parameter ID_SENT_PARAM, default 2, 16-bit frame ID of a SENT parameter frame.
REQ-003 SHALL have parameter CLK_FREQ, default 100000000, module clock frequency in Hz, integer multiple of 1000000.
REQ-004 SHALL have ports, in this order:
- clk  input  1  module clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_axis_udp_tdata  input  32  UDP payload word.
- rx_axis_udp_tvalid  input  1  word valid; always accepted, no tready.
- rx_axis_udp_tlast  input  1  last word of frame.
- cfg_wr  output  SENT_NUM  one-hot single-cycle write strobe, bit = channel.
- cfg_ctick_clk  output  14  clocks per tick = ctick_len*(CLK_FREQ/1000000).
- cfg_ltick_len  output  8  low-pulse ticks.
- cfg_pause_mode  output  2  0 none, 1 fixed, 2 variable.
- cfg_pause_len  output  10  pause length in ticks.
- cfg_crc_mode  output  1  0 legacy, 1 recommended.
- frame_err  output  1  single-cycle pulse on any rejected frame.
- err_cnt  output  16  saturating count of rejected frames.

Function
REQ-005 Frame format SHALL be 3 words: W0 = {id[15:0], channel[7:0], 8'h0}; W1 = {ctick_len[7:0], ltick_len[7:0], 6'h0, pause_mode[1:0], pause_len[15:8]}; W2 = {pause_len[7:0], 7'h0, crc_mode, 16'h0}, tlast on W2 only.
REQ-006 FSM states SHALL be IDLE, W1, W2, DROP; only beats with tvalid=1 advance the FSM.
REQ-007 IDLE: beat with id==ID_SENT_PARAM and tlast=0 -> W1; id match with tlast=1 -> IDLE plus error; id mismatch with tlast=0 -> DROP silently; id mismatch with tlast=1 -> IDLE silently.
REQ-008 W1: tlast=0 -> capture fields, go W2; tlast=1 -> IDLE plus error.
REQ-009 W2: tlast=1 -> validate, go IDLE; tlast=0 -> DROP plus error (frame too long).
REQ-010 DROP: stay until a beat with tlast=1, then IDLE; no outputs change.
REQ-011 Validation at W2 SHALL reject when: channel >= SENT_NUM; ctick_len outside 3..90; ltick_len < 4; pause_mode == 3; pause_mode != 0 and pause_len outside 12..768.
REQ-012 Valid frame: cfg_wr[channel]=1 for exactly one cycle, the cycle after the W2 beat; cfg_* fields valid in the same cycle and held until the next valid frame.
REQ-013 Rejected frame: frame_err=1 for one cycle, the cycle after the rejecting beat; cfg_wr stays 0; err_cnt increments, saturating at 16'hFFFF.
REQ-014 cfg_ctick_clk SHALL be computed with a constant multiplier fixed at elaboration; no divider in logic.
REQ-015 Back-to-back frames (W0 in the cycle after W2) SHALL be accepted without bubble.
REQ-016 Gaps (tvalid=0) inside a frame SHALL be tolerated in any state.

Reset
REQ-017 With rst_n low: FSM=IDLE; cfg_wr=0; frame_err=0; err_cnt=0; cfg_ctick_clk=0; cfg_ltick_len=0; cfg_pause_mode=0; cfg_pause_len=0; cfg_crc_mode=0.
REQ-018 Reset asserted mid-frame SHALL abandon the frame; the first beat after release is treated as W0.

Structure
REQ-019 Shared package sent_pkg SHALL hold the pause-mode and CRC-mode encodings, range limits (3, 90, 4, 12, 768) and the frame word count.
REQ-020 No sub-module is required; the validation check may be a function in sent_pkg.

Verification
REQ-021 ch=0, ctick=3, ltick=4, pause_mode=0, pause_len=10, crc=0, CLK_FREQ=100 MHz -> cfg_wr=5'b00001 one cycle after W2, cfg_ctick_clk=300, no frame_err.
REQ-022 ch=4, ctick=90, ltick=5, pause_mode=2, pause_len=768, crc=1 -> cfg_wr=5'b10000, cfg_ctick_clk=9000, cfg_pause_len=768; then same with pause_len=769 -> frame_err, err_cnt=1.
REQ-023 id=3 frame of 5 words -> no outputs change; the following valid frame for ch=1 -> cfg_wr=5'b00010.
REQ-024 ch=5, then ctick=2, then pause_mode=3 -> three frame_err pulses, err_cnt=3, cfg_wr never set.
REQ-025 tlast on W1; and a W2 without tlast followed by 2 extra words -> one frame_err each, FSM back in IDLE, the next valid frame is accepted.
REQ-026 rst_n pulsed low after W1, then a full valid frame for ch=2 -> all outputs reset, then cfg_wr=5'b00100 with the new fields.
